pcs_log_capture: RTL and testbench

//  Capture RAM directly downstream of PCS_modules. Records the decoded RX stream
//  ({rx_raw_ctrl, rx_raw_data}) per valid cycle into an on-chip log.
//  The register file later reads the log back over a random-access port.

---
 rtl/pcs_log_capture_if.sv | 28 ++
 rtl/pcs_log_capture.sv | 154 +++++++++++++++
 tb/tb_pcs_log_capture.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/pcs_log_capture_if.sv
// Bundle for pcs_log_capture: capture control, RX word input, readback port and status.
// The master modport is the producer/reader side; the slave modport is the capture RAM.
interface pcs_log_capture_if #(
    parameter int NB_DATA = 64,
    parameter int NB_CTRL = 8,
    parameter int NB_ADDR = 10
);
    logic               i_run;
    logic               i_valid;
    logic [NB_DATA-1:0] i_data;
    logic [NB_CTRL-1:0] i_ctrl;
    logic [NB_ADDR-1:0] i_read_addr;
    logic [NB_DATA-1:0] o_data;
    logic [NB_CTRL-1:0] o_ctrl;
    logic               o_full;
    logic               o_busy;
    logic [NB_ADDR:0]   o_wr_count;

    modport master (
        output i_run, i_valid, i_data, i_ctrl, i_read_addr,
        input  o_data, o_ctrl, o_full, o_busy, o_wr_count
    );

    modport slave (
        input  i_run, i_valid, i_data, i_ctrl, i_read_addr,
        output o_data, o_ctrl, o_full, o_busy, o_wr_count
    );
endinterface

// File: rtl/pcs_log_capture.sv
// Capture RAM for the decoded PCS RX stream with run/full control and registered readback.
// Optional control-character trigger (ARMED state) is enabled by defining PCS_LOG_TRIGGER_EN.
module pcs_log_capture #(
    parameter int NB_DATA = 64,
    parameter int NB_CTRL = 8,
    parameter int DEPTH   = 1024,
    parameter int NB_ADDR = $clog2(DEPTH)
`ifdef PCS_LOG_TRIGGER_EN
    ,
    parameter logic [NB_CTRL-1:0] TRIG_CTRL_MASK = {NB_CTRL{1'b1}}
`endif
) (
    input  logic             i_clock,
    input  logic             i_reset,
    pcs_log_capture_if.slave bus
);
    localparam int               NB_WORD = NB_CTRL + NB_DATA;
    localparam logic [NB_ADDR:0] DEPTH_C = (NB_ADDR + 1)'(DEPTH);
    localparam logic [NB_ADDR:0] LAST_C  = (NB_ADDR + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        FULL    = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               run_d;
    logic               run_rise;
    logic               wr_en;
    logic               start;
    logic               last_wr;
    logic [NB_ADDR:0]   wr_count;
    logic               full;
    logic [NB_WORD-1:0] mem [DEPTH];
    logic [NB_WORD-1:0] rd_word_p1;

    assign run_rise = bus.i_run & ~run_d;
    // wr_count doubles as the write pointer; it only reaches DEPTH once writes have stopped
    assign last_wr  = wr_en & (wr_count == LAST_C);

`ifdef PCS_LOG_TRIGGER_EN
    logic trig_hit;
    assign trig_hit = bus.i_valid & (|(bus.i_ctrl & TRIG_CTRL_MASK));
`endif

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (run_rise) begin
`ifdef PCS_LOG_TRIGGER_EN
                    state_nxt = ARMED;
`else
                    state_nxt = CAPTURE;
`endif
                end
            end
            ARMED: begin
`ifdef PCS_LOG_TRIGGER_EN
                if (!bus.i_run) begin
                    state_nxt = IDLE;
                end else if (trig_hit) begin
                    state_nxt = CAPTURE;
                end
`else
                state_nxt = IDLE;
`endif
            end
            CAPTURE: begin
                if (!bus.i_run) begin
                    state_nxt = IDLE;
                end else if (last_wr) begin
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (!bus.i_run) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wr_en = 1'b0;
        start = 1'b0;
        case (state)
            IDLE:    start = run_rise;
`ifdef PCS_LOG_TRIGGER_EN
            ARMED:   wr_en = trig_hit;
`endif
            CAPTURE: wr_en = bus.i_valid;
            default: begin
                wr_en = 1'b0;
                start = 1'b0;
            end
        endcase
    end

    // o_full is sticky across the return to IDLE and clears only when a new capture starts
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            run_d    <= 1'b0;
            wr_count <= '0;
            full     <= 1'b0;
        end else begin
            run_d <= bus.i_run;
            if (start) begin
                wr_count <= '0;
                full     <= 1'b0;
            end else if (wr_en) begin
                wr_count <= wr_count + 1'b1;
                if (last_wr) begin
                    full <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (wr_en) begin
            mem[wr_count[NB_ADDR-1:0]] <= {bus.i_ctrl, bus.i_data};
        end
    end

    // Readback stage p1: registered RAM read, no bypass of a same-cycle write
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            rd_word_p1 <= '0;
        end else if ({1'b0, bus.i_read_addr} < DEPTH_C) begin
            rd_word_p1 <= mem[bus.i_read_addr];
        end else begin
            rd_word_p1 <= '0;
        end
    end

    assign bus.o_data     = rd_word_p1[NB_DATA-1:0];
    assign bus.o_ctrl     = rd_word_p1[NB_WORD-1:NB_DATA];
    assign bus.o_full     = full;
    assign bus.o_busy     = (state == ARMED) || (state == CAPTURE);
    assign bus.o_wr_count = wr_count;
endmodule

// File: tb/tb_pcs_log_capture.sv
// Scoreboard bench for pcs_log_capture: a log model predicts status each cycle and
// readback words are queued at issue time and compared by an independent monitor.
module tb_pcs_log_capture;
    localparam int NB_DATA = 64;
    localparam int NB_CTRL = 8;
    localparam int DEPTH   = 16;
    localparam int NB_ADDR = 4;
    localparam logic [7:0] MASK = 8'hFF;
`ifdef PCS_LOG_TRIGGER_EN
    localparam bit TRIG_ON = 1'b1;
`else
    localparam bit TRIG_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pcs_log_capture_if #(.NB_DATA(NB_DATA), .NB_CTRL(NB_CTRL), .NB_ADDR(NB_ADDR)) bus ();

    pcs_log_capture #(
        .NB_DATA(NB_DATA),
        .NB_CTRL(NB_CTRL),
        .DEPTH  (DEPTH),
        .NB_ADDR(NB_ADDR)
    ) dut (
        .i_clock(clk),
        .i_reset(rst),
        .bus    (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference log: what each address should hold and whether it was written since reset
    logic [71:0] m_mem   [DEPTH];
    bit          m_known [DEPTH];
    int          m_cnt;
    bit          m_active;
    bit          m_armed;
    bit          m_prev_run;
    logic [72:0] rd_q[$];

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
        m_cnt      = 0;
        m_active   = 1'b0;
        m_armed    = 1'b0;
        m_prev_run = 1'b0;
        rd_q.delete();
    endtask

    // One clock: drive inputs at the negedge, let the model consume them at the posedge,
    // then compare status at the following negedge.
    task automatic step(input bit run, input bit valid, input logic [63:0] d,
                        input logic [7:0] c, input logic [3:0] ra);
        bit rise;
        bus.i_run       = run;
        bus.i_valid     = valid;
        bus.i_data      = d;
        bus.i_ctrl      = c;
        bus.i_read_addr = ra;
        @(posedge clk);
        rd_q.push_back({m_known[ra], m_mem[ra]});
        rise       = run && !m_prev_run;
        m_prev_run = run;
        if (m_active) begin
            if (valid && m_cnt < DEPTH && (!m_armed || ((c & MASK) != 8'h00))) begin
                m_mem[m_cnt]   = {c, d};
                m_known[m_cnt] = 1'b1;
                m_cnt++;
                m_armed = 1'b0;
            end
            if (!run || m_cnt == DEPTH) m_active = 1'b0;
        end else if (rise) begin
            m_cnt    = 0;
            m_active = 1'b1;
            m_armed  = TRIG_ON;
        end
        @(negedge clk);
        chk("wr_count", 72'(bus.o_wr_count), 72'(m_cnt));
        chk("full", 72'(bus.o_full), 72'(m_cnt == DEPTH));
        chk("busy", 72'(bus.o_busy), 72'(m_active));
    endtask

    function automatic logic [63:0] rword();
        return {$urandom(), $urandom()};
    endfunction

    initial begin : monitor
        logic [72:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && rd_q.size() > 0) begin
                e = rd_q.pop_front();
                if (e[72]) chk("readback", {bus.o_ctrl, bus.o_data}, e[71:0]);
            end
        end
    end

    initial begin : stim
        bit run;
        int hold;
        logic [7:0] c;
        bus.i_run = 1'b0; bus.i_valid = 1'b0; bus.i_data = '0; bus.i_ctrl = '0; bus.i_read_addr = '0;
        model_clear();
        repeat (2) @(negedge clk);
        chk("rst_count", 72'(bus.o_wr_count), 72'd0);
        chk("rst_full", 72'(bus.o_full), 72'd0);
        chk("rst_busy", 72'(bus.o_busy), 72'd0);
        chk("rst_data", {bus.o_ctrl, bus.o_data}, 72'd0);
        rst = 1'b0;

        // Five words then stop; readback of address 3
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 1, rword(), 8'h00, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 3);
        step(0, 0, 0, 0, 0);
`ifndef PCS_LOG_TRIGGER_EN
        chk("t1_count", 72'(bus.o_wr_count), 72'd5);
`endif

        // Fill to DEPTH with extra words dropped, read all, then restart from FULL
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(1, 1, rword(), 8'h01, 0);
        chk("t2_count", 72'(bus.o_wr_count), 72'(DEPTH));
        chk("t2_full", 72'(bus.o_full), 72'd1);
        for (int i = 0; i < DEPTH; i++) step(1, 1, rword(), 8'h01, 4'(i));
        step(0, 0, 0, 0, 15);
        chk("t5_full_held", 72'(bus.o_full), 72'd1);
        step(1, 0, 0, 0, 0);
        chk("t5_full_clr", 72'(bus.o_full), 72'd0);
        step(0, 0, 0, 0, 0);

        // Alternating valid packs four entries
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(1, (i % 2) == 0, rword(), 8'h01, 0);
        step(0, 0, 0, 0, 0);
        chk("t3_count", 72'(bus.o_wr_count), 72'd4);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 4'(i));

        // Reset in the middle of a capture
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(1, 1, rword(), 8'h01, 0);
        bus.i_run = 1'b0; bus.i_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("t4_count", 72'(bus.o_wr_count), 72'd0);
        chk("t4_busy", 72'(bus.o_busy), 72'd0);
        chk("t4_data", {bus.o_ctrl, bus.o_data}, 72'd0);
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 1, rword(), 8'h01, 0);
        step(1, 1, rword(), 8'h01, 0);
        step(0, 0, 0, 0, 0);
        chk("t4_restart", 72'(bus.o_wr_count), 72'd2);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);

`ifdef PCS_LOG_TRIGGER_EN
        // Trigger discards non-matching words and stores the trigger word at 0
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 1, rword(), 8'h00, 0);
        chk("t6_armed_busy", 72'(bus.o_busy), 72'd1);
        step(1, 1, rword(), 8'h80, 0);
        step(1, 1, rword(), 8'h00, 0);
        step(1, 1, rword(), 8'h00, 0);
        step(0, 0, 0, 0, 0);
        chk("t6_count", 72'(bus.o_wr_count), 72'd3);
        step(0, 0, 0, 0, 0);
`endif

        // Randomized run/valid/ctrl/readback traffic
        run  = 1'b1;
        hold = 0;
        for (int i = 0; i < 800; i++) begin
            if (run) begin
                if ($urandom_range(0, 39) == 0) begin
                    run  = 1'b0;
                    hold = $urandom_range(2, 4);
                end
            end else begin
                hold--;
                if (hold <= 0) run = 1'b1;
            end
            c = ($urandom_range(0, 3) == 0) ? 8'($urandom()) : 8'h00;
            step(run, 1'($urandom_range(0, 1)), rword(), c, 4'($urandom_range(0, DEPTH - 1)));
        end
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
